seg7_scan_driver: RTL



---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_digit_decode.sv | 31 +++
 rtl/seg7_scan_driver.sv | 83 ++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment type, blank pattern and active-low glyphs (bit6 = a .. bit0 = g)
package seg7_pkg;
  typedef logic [6:0] seg7_t;
  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_0 = 7'b0000001;
  localparam seg7_t SEG_1 = 7'b1001111;
  localparam seg7_t SEG_2 = 7'b0010010;
  localparam seg7_t SEG_3 = 7'b0000110;
  localparam seg7_t SEG_4 = 7'b1001100;
  localparam seg7_t SEG_5 = 7'b0100100;
  localparam seg7_t SEG_6 = 7'b0100000;
  localparam seg7_t SEG_7 = 7'b0001111;
  localparam seg7_t SEG_8 = 7'b0000000;
  localparam seg7_t SEG_9 = 7'b0000100;
  localparam seg7_t SEG_A = 7'b0001000;
  localparam seg7_t SEG_B = 7'b1100000;
  localparam seg7_t SEG_C = 7'b0110001;
  localparam seg7_t SEG_D = 7'b1000010;
  localparam seg7_t SEG_E = 7'b0110000;
  localparam seg7_t SEG_F = 7'b0111000;
endpackage

// File: rtl/seg7_digit_decode.sv
// seg7_digit_decode: nibble -> active-low glyph; 10..15 blank unless SEG7_HEX_DIGITS_EN is defined
// ports: nib (4-bit digit in), seg (seg7_t out)
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg7_t      seg
);
  always_comb
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
`ifdef SEG7_HEX_DIGITS_EN
      4'd10: seg = SEG_A;
      4'd11: seg = SEG_B;
      4'd12: seg = SEG_C;
      4'd13: seg = SEG_D;
      4'd14: seg = SEG_E;
      4'd15: seg = SEG_F;
`endif
      default: seg = SEG_BLANK;
    endcase
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered multiplexed 7-segment scanner with guard blanking (hex glyphs via SEG7_HEX_DIGITS_EN)
// ports: clk, rst (sync, active-high); load/digits_in/dp_in/blank_in capture a word;
// seg_n/dp_n/an drive the display pins; update_pending, frame_start report status
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int GUARD_CYCLES     = 2,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output seg7_t                   seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    update_pending,
  output logic                    frame_start
);
  localparam int PW = $clog2(REFRESH_DIV + 1);
  localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int WW = 6 * NUM_DIGITS;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};
  // word layout: {blank, dp, digits}
  logic [WW-1:0] word_in, disp_q, disp_d, pend_q, pend_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] sel_q, sel_d;
  logic upd_q, upd_d, fs_q, fs_d, dp_q, dp_d, tick, boundary, guard, blank;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0] nib;
  seg7_t seg_q, seg_d, glyph;
  seg7_digit_decode u_dec (.nib(nib), .seg(glyph));
  always_comb begin
    word_in  = {blank_in, dp_in, digits_in};
    tick     = presc_q == PW'(REFRESH_DIV - 1);
    boundary = tick && sel_q == SW'(NUM_DIGITS - 1);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    sel_d    = !tick ? sel_q : boundary ? '0 : sel_q + 1'b1;
    // a load on the boundary bypasses the pending buffer straight to the display
    disp_d   = !boundary ? disp_q : load ? word_in : upd_q ? pend_q : disp_q;
    pend_d   = load ? word_in : pend_q;
    upd_d    = load ? !boundary : upd_q && !boundary;
    nib      = disp_q[4*sel_q +: 4];
    blank    = disp_q[5*NUM_DIGITS + int'(sel_q)];
    guard    = int'(presc_q) < GUARD_CYCLES;
    // XOR with the idle pattern yields the one-hot enable in either polarity
    an_d     = guard ? AN_OFF : AN_OFF ^ (NUM_DIGITS'(1) << sel_q);
    seg_d    = guard || blank ? SEG_BLANK : glyph;
    dp_d     = guard || blank || !disp_q[4*NUM_DIGITS + int'(sel_q)];
    fs_d     = boundary;
  end
  always_ff @(posedge clk)
    if (rst) begin
      presc_q <= '0;
      sel_q   <= '0;
      disp_q  <= '0;
      pend_q  <= '0;
      upd_q   <= 1'b0;
      fs_q    <= 1'b0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      an_q    <= AN_OFF;
    end else begin
      presc_q <= presc_d;
      sel_q   <= sel_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      upd_q   <= upd_d;
      fs_q    <= fs_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  assign seg_n          = seg_q;
  assign dp_n           = dp_q;
  assign an             = an_q;
  assign update_pending = upd_q;
  assign frame_start    = fs_q;
endmodule
